// File: rtl/nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : nes_clock_enable_gen
// Description : Multi-channel clock-enable generator (CPU/PPU/APU) on clk_mst
//               with NTSC/PAL divisor sets, phase offsets and halt/step.
//               Optional macro CLKEN_TICK_CNT_EN enables the 32-bit ch0 tick
//               counter on tick_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_clock_enable_gen #(
    parameter int                        NUM_CH   = 3,
    parameter int                        CNT_W    = 6,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_NTSC = {6'd24, 6'd4, 6'd12},
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_PAL  = {6'd32, 6'd5, 6'd16},
    parameter logic [NUM_CH*CNT_W-1:0]   PHASE    = '0
) (
    input  logic              clk_mst,
    input  logic              rst,
    input  logic              run,
    input  logic              step_req,
    output logic              step_ack,
    input  logic              mode_sel,
    output logic              mode_act,
    output logic [NUM_CH-1:0] ce,
    output logic              halted,
    output logic [31:0]       tick_cnt
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mode_act;
    logic              r_mode_req;
    logic              r_step_ack;
    logic [NUM_CH-1:0] r_ce;
    logic [NUM_CH-1:0] w_wrap;
    logic              w_counting;
    logic              w_ce0;
    logic              w_mode_apply;

    assign w_counting   = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_ce0        = w_wrap[0];
    // A pending mode lands only on a ch0 tick so the CPU never sees a torn period.
    assign w_mode_apply = w_ce0 && (r_mode_req != r_mode_act);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_div;
            logic [CNT_W-1:0] w_last;

            assign w_div      = r_mode_act ? DIV_PAL[gi*CNT_W +: CNT_W]
                                           : DIV_NTSC[gi*CNT_W +: CNT_W];
            assign w_last     = (w_div == '0) ? '0 : (w_div - c_one);
            assign w_wrap[gi] = w_counting && (r_cnt == w_last);

            always_ff @(posedge clk_mst) begin
                if (rst) begin
                    r_cnt <= PHASE[gi*CNT_W +: CNT_W];
                end else if (w_mode_apply) begin
                    r_cnt <= PHASE[gi*CNT_W +: CNT_W];
                end else if (w_wrap[gi]) begin
                    r_cnt <= '0;
                end else if (w_counting) begin
                    r_cnt <= r_cnt + c_one;
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_ce0 && !run) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                end else if (step_req) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (w_ce0) begin
                    w_state_nxt = run ? ST_RUN : ST_HALT;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_mst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_ce       <= '0;
            r_step_ack <= 1'b0;
            r_mode_act <= 1'b0;
            r_mode_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ce       <= w_wrap;
            r_step_ack <= (r_state == ST_STEP) && w_ce0;
            r_mode_req <= mode_sel;
            if (w_mode_apply) begin
                r_mode_act <= r_mode_req;
            end
        end
    end

`ifdef CLKEN_TICK_CNT_EN
    logic [31:0] r_tick_cnt;

    always_ff @(posedge clk_mst) begin
        if (rst) begin
            r_tick_cnt <= 32'd0;
        end else if (w_ce0) begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
        end
    end

    assign tick_cnt = r_tick_cnt;
`else
    assign tick_cnt = 32'd0;
`endif

    assign ce       = r_ce;
    assign step_ack = r_step_ack;
    assign mode_act = r_mode_act;
    assign halted   = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_clock_enable_gen
// Description : Directed self-checking bench for nes_clock_enable_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_clock_enable_gen;

`ifdef CLKEN_TICK_CNT_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic        clk_mst  = 1'b0;
    logic        rst      = 1'b1;
    logic        run      = 1'b1;
    logic        step_req = 1'b0;
    logic        mode_sel = 1'b0;
    logic        step_ack, mode_act, halted;
    logic [2:0]  ce;
    logic [31:0] tick_cnt;
    logic        p_step_ack, p_mode_act, p_halted;
    logic [2:0]  p_ce;
    logic [31:0] p_tick_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_mst = ~clk_mst;

    nes_clock_enable_gen dut (
        .clk_mst  (clk_mst),
        .rst      (rst),
        .run      (run),
        .step_req (step_req),
        .step_ack (step_ack),
        .mode_sel (mode_sel),
        .mode_act (mode_act),
        .ce       (ce),
        .halted   (halted),
        .tick_cnt (tick_cnt)
    );

    nes_clock_enable_gen #(
        .PHASE ({6'd0, 6'd2, 6'd0})
    ) dut_ph (
        .clk_mst  (clk_mst),
        .rst      (rst),
        .run      (run),
        .step_req (step_req),
        .step_ack (p_step_ack),
        .mode_sel (mode_sel),
        .mode_act (p_mode_act),
        .ce       (p_ce),
        .halted   (p_halted),
        .tick_cnt (p_tick_cnt)
    );

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk_mst);
        @(negedge clk_mst);
    endtask

    task automatic do_reset(input logic run_v, input logic mode_v);
        rst      = 1'b1;
        run      = run_v;
        mode_sel = mode_v;
        step_req = 1'b0;
        cyc();
        cyc();
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b0);
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        n_cmp++; if (ce !== 3'b000) begin n_err++; $display("FAIL reset_ce: got %b want 000", ce); end
        n_cmp++; if (step_ack !== 1'b0) begin n_err++; $display("FAIL reset_step_ack: got %b want 0", step_ack); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (mode_act !== 1'b0) begin n_err++; $display("FAIL reset_mode_act: got %b want 0", mode_act); end
        n_cmp++; if (tick_cnt !== 32'd0) begin n_err++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
        n_cmp++; if ({p_ce, p_step_ack, p_halted, p_mode_act} !== 6'b0) begin
            n_err++; $display("FAIL reset_phase_dut: got %b want 000000", {p_ce, p_step_ack, p_halted, p_mode_act});
        end
        n_cmp++; if (p_tick_cnt !== 32'd0) begin n_err++; $display("FAIL reset_phase_tick: got %0d want 0", p_tick_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_ntsc();
        logic [2:0]  exp;
        logic [31:0] exp_t;
        do_reset(1'b1, 1'b0);
        for (int n = 1; n <= 48; n++) begin
            cyc();
            exp = {n % 24 == 0, n % 4 == 0, n % 12 == 0};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL ntsc_ce cyc %0d: got %b want %b", n, ce, exp); end
            exp = {n % 24 == 0, n % 4 == 2, n % 12 == 0};
            n_cmp++; if (p_ce !== exp) begin n_err++; $display("FAIL phase_ce cyc %0d: got %b want %b", n, p_ce, exp); end
        end
        exp_t = TICK_EN ? 32'd4 : 32'd0;
        n_cmp++; if (tick_cnt !== exp_t) begin n_err++; $display("FAIL ntsc_tick_cnt: got %0d want %0d", tick_cnt, exp_t); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL ntsc_halted: got %b want 0", halted); end
    endtask

    task automatic test_halt_resume();
        logic [2:0] exp;
        do_reset(1'b1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) run = 1'b0;
            cyc();
            exp = {1'b0, n % 4 == 0, n == 12};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL halt_ce cyc %0d: got %b want %b", n, ce, exp); end
        end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_entry: got %b want 1", halted); end
        for (int n = 1; n <= 20; n++) begin
            cyc();
            n_cmp++; if (ce !== 3'b000) begin n_err++; $display("FAIL halt_hold_ce cyc %0d: got %b want 000", n, ce); end
            n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_hold cyc %0d: got %b want 1", n, halted); end
        end
        run = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            cyc();
            exp = {n == 13, n == 5 || n == 9 || n == 13, n == 13};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL resume_ce cyc %0d: got %b want %b", n, ce, exp); end
            if (n == 1) begin
                n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", halted); end
            end
        end
    endtask

    task automatic test_single_step();
        logic [2:0]  exp;
        logic [31:0] exp_t;
        int          pulses;
        do_reset(1'b0, 1'b0);
        repeat (12) cyc();
        n_cmp++; if (ce !== 3'b011) begin n_err++; $display("FAIL step_pre_ce: got %b want 011", ce); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL step_pre_halted: got %b want 1", halted); end
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        n_cmp++; if ({ce, halted} !== 4'b0000) begin n_err++; $display("FAIL step_start: got %b want 0000", {ce, halted}); end
        pulses = 0;
        for (int m = 1; m <= 12; m++) begin
            if (m == 3) step_req = 1'b1;
            if (m == 4) step_req = 1'b0;
            cyc();
            exp = {m == 12, m % 4 == 0, m == 12};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL step_ce m %0d: got %b want %b", m, ce, exp); end
            n_cmp++; if (step_ack !== (m == 12)) begin n_err++; $display("FAIL step_ack m %0d: got %b want %b", m, step_ack, m == 12); end
            n_cmp++; if (halted !== (m == 12)) begin n_err++; $display("FAIL step_halted m %0d: got %b want %b", m, halted, m == 12); end
            pulses = pulses + int'(ce[1]);
        end
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL step_ce1_count: got %0d want 3", pulses); end
        for (int m = 1; m <= 5; m++) begin
            cyc();
            n_cmp++; if ({ce, step_ack, halted} !== 5'b00001) begin
                n_err++; $display("FAIL step_after m %0d: got %b want 00001", m, {ce, step_ack, halted});
            end
        end
        exp_t = TICK_EN ? 32'd2 : 32'd0;
        n_cmp++; if (tick_cnt !== exp_t) begin n_err++; $display("FAIL step_tick_cnt: got %0d want %0d", tick_cnt, exp_t); end
    endtask

    task automatic test_mode_switch();
        logic [2:0]  exp;
        logic [31:0] exp_t;
        do_reset(1'b1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) mode_sel = 1'b1;
            cyc();
            exp = {n % 24 == 0, n % 4 == 0, n % 12 == 0};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL mode_pre_ce cyc %0d: got %b want %b", n, ce, exp); end
            n_cmp++; if (mode_act !== (n == 12)) begin n_err++; $display("FAIL mode_act cyc %0d: got %b want %b", n, mode_act, n == 12); end
        end
        for (int k = 1; k <= 80; k++) begin
            if (k == 49) mode_sel = 1'b0;
            if (k == 51) mode_sel = 1'b1;
            if (k == 65) begin
                mode_sel = 1'b0;
                run      = 1'b0;
            end
            cyc();
            exp = {k % 32 == 0, k % 5 == 0, k % 16 == 0};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL pal_ce k %0d: got %b want %b", k, ce, exp); end
            if (k == 48 || k == 64) begin
                n_cmp++; if (mode_act !== 1'b1) begin n_err++; $display("FAIL pal_mode_act k %0d: got %b want 1", k, mode_act); end
            end
        end
        n_cmp++; if ({mode_act, halted} !== 2'b01) begin n_err++; $display("FAIL mode_and_halt: got %b want 01", {mode_act, halted}); end
        exp_t = TICK_EN ? 32'd6 : 32'd0;
        n_cmp++; if (tick_cnt !== exp_t) begin n_err++; $display("FAIL mode_tick_cnt: got %0d want %0d", tick_cnt, exp_t); end
        mode_sel = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            n_cmp++; if ({ce, mode_act, halted} !== 5'b00001) begin
                n_err++; $display("FAIL mode_defer k %0d: got %b want 00001", k, {ce, mode_act, halted});
            end
        end
        run = 1'b1;
    endtask

    task automatic test_reset_mid_step();
        logic [2:0] exp;
        do_reset(1'b0, 1'b1);
        repeat (12) cyc();
        n_cmp++; if ({mode_act, halted} !== 2'b11) begin n_err++; $display("FAIL rms_pre: got %b want 11", {mode_act, halted}); end
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        repeat (6) cyc();
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rms_in_step: got %b want 0", halted); end
        rst      = 1'b1;
        mode_sel = 1'b0;
        run      = 1'b1;
        cyc();
        n_cmp++; if ({ce, step_ack, halted, mode_act} !== 6'b0) begin
            n_err++; $display("FAIL rms_reset_outputs: got %b want 000000", {ce, step_ack, halted, mode_act});
        end
        n_cmp++; if (tick_cnt !== 32'd0) begin n_err++; $display("FAIL rms_tick_cnt: got %0d want 0", tick_cnt); end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            exp = {1'b0, n % 4 == 0, n == 12};
            n_cmp++; if (ce !== exp) begin n_err++; $display("FAIL rms_after_ce cyc %0d: got %b want %b", n, ce, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_ntsc();
        test_halt_resume();
        test_single_step();
        test_mode_switch();
        test_reset_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
